sram_bus_arbiter: RTL

Two-master, one-slave arbiter for the SRAM-like request/addr_ok/data_ok protocol. It sits between `cache_module` and `cpu_axi_interface` and shares one slave port between the instruction and data requesters. It allows one outstanding transaction at a time, uses round-robin grant on contention and has a data-phase watchdog.

---
 rtl/sram_bus_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: round-robin two-master arbiter onto one SRAM-like slave, one transaction in flight
// with a data-phase watchdog that answers the master with zero data when the slave never responds.
module sram_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic [31:0]      inst_rdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic [31:0]      data_rdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic             s_req,
  output logic             s_wr,
  output logic [1:0]       s_size,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_wdata,
  input  logic [31:0]      s_rdata,
  input  logic             s_addr_ok,
  input  logic             s_data_ok,
  output logic             grant_data,
  output logic             timeout_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic last_data;
  logic [CNT_W-1:0] cnt;
  logic in_addr, in_data, sel_inst, fire, done;
  assign in_addr  = state == ADDR;
  assign in_data  = state == DATA;
  // The slave mux defaults to the data master whenever the inst master is not being served.
  assign sel_inst = in_addr & ~grant_data;
  assign fire     = in_data & ~s_data_ok & (cnt == CNT_W'(TIMEOUT - 1));
  assign done     = in_data & (s_data_ok | fire);
  assign s_req    = in_addr;
  assign s_wr     = sel_inst ? inst_wr    : data_wr;
  assign s_size   = sel_inst ? inst_size  : data_size;
  assign s_addr   = sel_inst ? inst_addr  : data_addr;
  assign s_wdata  = sel_inst ? inst_wdata : data_wdata;
  assign inst_addr_ok = in_addr & s_addr_ok & ~grant_data;
  assign data_addr_ok = in_addr & s_addr_ok & grant_data;
  assign inst_data_ok = done & ~grant_data;
  assign data_data_ok = done & grant_data;
  assign inst_rdata   = fire ? '0 : s_rdata;
  assign data_rdata   = fire ? '0 : s_rdata;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      grant_data  <= 1'b0;
      last_data   <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (inst_req | data_req) begin
          state      <= ADDR;
          grant_data <= data_req & ~(inst_req & last_data);
        end
        ADDR: if (s_addr_ok) begin
          state     <= DATA;
          cnt       <= '0;
          last_data <= grant_data;
        end
        DATA: if (done) begin
          state       <= IDLE;
          timeout_err <= timeout_err | fire;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
